// File: rtl/fb_pkg.sv
// Shared framebuffer types: default widths, bank select, writer id and arbiter FSM states.
// Used by the arbiter and by the cursor and paint writers.
package fb_pkg;

  localparam int unsigned FbAddrW = 12;
  localparam int unsigned FbDataW = 12;

  typedef enum logic {
    Bank0 = 1'b0,
    Bank1 = 1'b1
  } fb_bank_e;

  typedef enum logic {
    Writer0 = 1'b0,
    Writer1 = 1'b1
  } fb_writer_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRd   = 2'd1,
    StWr   = 2'd2
  } fb_state_e;

endpackage

// File: rtl/fb_rr_sched.sv
// Slot scheduler: read has priority, writers share slots round-robin, and a run of
// STARVE_MAX read grants with a writer waiting forces the next slot to a writer.
module fb_rr_sched
  import fb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic rd_req_i,
  input  logic w0_req_i,
  input  logic w1_req_i,
  input  logic w0_gnt_i,
  input  logic w1_gnt_i,
  output logic gnt_rd_o,
  output logic gnt_w0_o,
  output logic gnt_w1_o
);

  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  fb_writer_e      rr_q, rr_d;
  logic            w0_pend, w1_pend, any_pend, starved, pick_w1;

  always_comb begin
    // A writer granted this cycle still shows req at this edge; it must not win again.
    w0_pend  = w0_req_i & ~w0_gnt_i;
    w1_pend  = w1_req_i & ~w1_gnt_i;
    any_pend = w0_pend | w1_pend;
    starved  = any_pend && (cnt_q >= CntW'(STARVE_MAX));
    pick_w1  = w1_pend && (!w0_pend || (rr_q == Writer1));

    gnt_rd_o = rd_req_i && !starved;
    gnt_w0_o = !gnt_rd_o && w0_pend && !pick_w1;
    gnt_w1_o = !gnt_rd_o && pick_w1;

    cnt_d = '0;
    if (gnt_rd_o && any_pend) begin
      cnt_d = cnt_q + 1'b1;
    end

    rr_d = rr_q;
    if (gnt_w0_o) begin
      rr_d = Writer1;
    end else if (gnt_w1_o) begin
      rr_d = Writer0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      rr_q  <= Writer0;
    end else begin
      cnt_q <= cnt_d;
      rr_q  <= rr_d;
    end
  end

endmodule

// File: rtl/fb_arbiter.sv
// Framebuffer memory arbiter: one panel-scan reader and two writers share a two-bank
// memory, one registered command per cycle, with a two-edge read data pipe.
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int unsigned ADDR_W     = FbAddrW,
  parameter int unsigned DATA_W     = FbDataW,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_req,
  input  logic              rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              w0_req,
  input  logic              w0_bank,
  input  logic [ADDR_W-1:0] w0_addr,
  input  logic [DATA_W-1:0] w0_wdata,
  output logic              w0_gnt,
  input  logic              w1_req,
  input  logic              w1_bank,
  input  logic [ADDR_W-1:0] w1_addr,
  input  logic [DATA_W-1:0] w1_wdata,
  output logic              w1_gnt,
  input  logic [DATA_W-1:0] b_rdata0,
  input  logic [DATA_W-1:0] b_rdata1,
  output logic              wr0,
  output logic              wr1,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] wdata,
  output logic              rd_en
);

  fb_state_e         state_q, state_d;
  logic              wr0_q, wr0_d, wr1_q, wr1_d;
  logic              w0_gnt_q, w0_gnt_d, w1_gnt_q, w1_gnt_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  fb_bank_e          rd_bank_q, rd_bank_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              gnt_rd, gnt_w0, gnt_w1;

  fb_rr_sched #(
    .STARVE_MAX(STARVE_MAX)
  ) u_sched (
    .clk     (clk),
    .reset   (reset),
    .rd_req_i(rd_req),
    .w0_req_i(w0_req),
    .w1_req_i(w1_req),
    .w0_gnt_i(w0_gnt_q),
    .w1_gnt_i(w1_gnt_q),
    .gnt_rd_o(gnt_rd),
    .gnt_w0_o(gnt_w0),
    .gnt_w1_o(gnt_w1)
  );

  always_comb begin
    state_d   = StIdle;
    wr0_d     = 1'b0;
    wr1_d     = 1'b0;
    w0_gnt_d  = 1'b0;
    w1_gnt_d  = 1'b0;
    address_d = address_q;
    wdata_d   = wdata_q;
    rd_bank_d = rd_bank_q;

    if (gnt_rd) begin
      state_d   = StRd;
      address_d = rd_addr;
      rd_bank_d = fb_bank_e'(rd_bank);
    end else if (gnt_w0) begin
      state_d   = StWr;
      w0_gnt_d  = 1'b1;
      address_d = w0_addr;
      wdata_d   = w0_wdata;
      wr0_d     = (fb_bank_e'(w0_bank) == Bank0);
      wr1_d     = (fb_bank_e'(w0_bank) == Bank1);
    end else if (gnt_w1) begin
      state_d   = StWr;
      w1_gnt_d  = 1'b1;
      address_d = w1_addr;
      wdata_d   = w1_wdata;
      wr0_d     = (fb_bank_e'(w1_bank) == Bank0);
      wr1_d     = (fb_bank_e'(w1_bank) == Bank1);
    end

    // Bank data for the read issued last cycle is present now; capture it.
    rd_valid_d = (state_q == StRd);
    rd_data_d  = rd_data_q;
    if (state_q == StRd) begin
      rd_data_d = (rd_bank_q == Bank1) ? b_rdata1 : b_rdata0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      wr0_q      <= 1'b0;
      wr1_q      <= 1'b0;
      w0_gnt_q   <= 1'b0;
      w1_gnt_q   <= 1'b0;
      address_q  <= '0;
      wdata_q    <= '0;
      rd_bank_q  <= Bank0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr0_q      <= wr0_d;
      wr1_q      <= wr1_d;
      w0_gnt_q   <= w0_gnt_d;
      w1_gnt_q   <= w1_gnt_d;
      address_q  <= address_d;
      wdata_q    <= wdata_d;
      rd_bank_q  <= rd_bank_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_en    = (state_q == StRd);
  assign rd_gnt   = (state_q == StRd);
  assign wr0      = wr0_q;
  assign wr1      = wr1_q;
  assign w0_gnt   = w0_gnt_q;
  assign w1_gnt   = w1_gnt_q;
  assign address  = address_q;
  assign wdata    = wdata_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter: directed scenarios plus randomized traffic
// scored against a slot-level reference model.
module tb_fb_arbiter;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 12;
  localparam int unsigned SM = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          rd_req, rd_bank;
  logic [AW-1:0] rd_addr;
  logic          rd_gnt, rd_valid;
  logic [DW-1:0] rd_data;
  logic          w0_req, w0_bank, w0_gnt;
  logic [AW-1:0] w0_addr;
  logic [DW-1:0] w0_wdata;
  logic          w1_req, w1_bank, w1_gnt;
  logic [AW-1:0] w1_addr;
  logic [DW-1:0] w1_wdata;
  logic [DW-1:0] b_rdata0, b_rdata1;
  logic          wr0, wr1, rd_en;
  logic [AW-1:0] address;
  logic [DW-1:0] wdata;

  int checks = 0;
  int errors = 0;

  // Reference model state: what the outputs should show after the next edge.
  int            m_rr, m_streak;
  bit            m_rd_en, m_w0g, m_w1g, m_wr0, m_wr1, m_rd_bank, m_valid;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;

  fb_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .STARVE_MAX(SM)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .rd_req  (rd_req),
    .rd_bank (rd_bank),
    .rd_addr (rd_addr),
    .rd_gnt  (rd_gnt),
    .rd_valid(rd_valid),
    .rd_data (rd_data),
    .w0_req  (w0_req),
    .w0_bank (w0_bank),
    .w0_addr (w0_addr),
    .w0_wdata(w0_wdata),
    .w0_gnt  (w0_gnt),
    .w1_req  (w1_req),
    .w1_bank (w1_bank),
    .w1_addr (w1_addr),
    .w1_wdata(w1_wdata),
    .w1_gnt  (w1_gnt),
    .b_rdata0(b_rdata0),
    .b_rdata1(b_rdata1),
    .wr0     (wr0),
    .wr1     (wr1),
    .address (address),
    .wdata   (wdata),
    .rd_en   (rd_en)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rd_req = 0; rd_bank = 0; rd_addr = '0;
    w0_req = 0; w0_bank = 0; w0_addr = '0; w0_wdata = '0;
    w1_req = 0; w1_bank = 0; w1_addr = '0; w1_wdata = '0;
    b_rdata0 = '0; b_rdata1 = '0;
  endtask

  task automatic model_reset();
    m_rr = 0; m_streak = 0;
    m_rd_en = 0; m_w0g = 0; m_w1g = 0; m_wr0 = 0; m_wr1 = 0; m_rd_bank = 0; m_valid = 0;
    m_addr = '0; m_wdata = '0; m_rdata = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    model_reset();
  endtask

  // Decide the slot for the coming edge from the current (stable) inputs.
  task automatic model_edge();
    bit w0p, w1p, anyw;
    int win;
    m_valid = m_rd_en;
    if (m_rd_en) m_rdata = m_rd_bank ? b_rdata1 : b_rdata0;
    w0p  = w0_req && !m_w0g;
    w1p  = w1_req && !m_w1g;
    anyw = w0p || w1p;
    if (rd_req && !(anyw && m_streak >= int'(SM))) win = 2;
    else if (w0p && w1p) win = m_rr;
    else if (w0p) win = 0;
    else if (w1p) win = 1;
    else win = -1;
    m_streak = (win == 2 && anyw) ? m_streak + 1 : 0;
    m_rd_en = (win == 2);
    m_w0g = (win == 0);
    m_w1g = (win == 1);
    m_wr0 = 0;
    m_wr1 = 0;
    if (win == 2) begin
      m_addr = rd_addr;
      m_rd_bank = rd_bank;
    end else if (win == 0) begin
      m_addr = w0_addr; m_wdata = w0_wdata; m_wr0 = !w0_bank; m_wr1 = w0_bank; m_rr = 1;
    end else if (win == 1) begin
      m_addr = w1_addr; m_wdata = w1_wdata; m_wr0 = !w1_bank; m_wr1 = w1_bank; m_rr = 0;
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    rd_req = 1; w0_req = 1; w1_req = 1;
    @(posedge clk);
    #1;
    checks++;
    if ({rd_en, rd_gnt, wr0, wr1, w0_gnt, w1_gnt, rd_valid} !== 7'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b want 0000000",
               {rd_en, rd_gnt, wr0, wr1, w0_gnt, w1_gnt, rd_valid});
    end
    checks++;
    if (address !== '0 || wdata !== '0) begin
      errors++;
      $display("FAIL reset_cmd: got addr %h wdata %h want 000 000", address, wdata);
    end
    checks++;
    if (rd_data !== '0) begin
      errors++;
      $display("FAIL reset_rd_data: got %h want 000", rd_data);
    end
    reset = 0;
    clear_inputs();
  endtask

  task automatic test_single_write();
    apply_reset();
    w0_req = 1; w0_bank = 1; w0_addr = 12'h07F; w0_wdata = 12'h004;
    tick();
    checks++;
    if ({w0_gnt, w1_gnt, wr0, wr1, rd_en} !== 5'b10010) begin
      errors++;
      $display("FAIL single_write_strobes: got %b want 10010", {w0_gnt, w1_gnt, wr0, wr1, rd_en});
    end
    checks++;
    if (address !== 12'h07F || wdata !== 12'h004) begin
      errors++;
      $display("FAIL single_write_cmd: got %h/%h want 07f/004", address, wdata);
    end
    w0_req = 0;
    tick();
    checks++;
    if ({w0_gnt, w1_gnt, wr0, wr1, rd_en} !== 5'b00000) begin
      errors++;
      $display("FAIL single_write_one_cycle: got %b want 00000", {w0_gnt, w1_gnt, wr0, wr1, rd_en});
    end
    checks++;
    if (address !== 12'h07F || wdata !== 12'h004) begin
      errors++;
      $display("FAIL idle_hold_cmd: got %h/%h want 07f/004", address, wdata);
    end
  endtask

  task automatic test_alternate();
    logic [AW-1:0] exp_addr;
    logic [1:0]    exp_g;
    apply_reset();
    w0_req = 1; w0_bank = 0; w0_addr = 12'h010; w0_wdata = 12'h111;
    w1_req = 1; w1_bank = 1; w1_addr = 12'h020; w1_wdata = 12'h222;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp_g    = (i % 2 == 0) ? 2'b10 : 2'b01;
      exp_addr = (i % 2 == 0) ? 12'h010 : 12'h020;
      checks++;
      if ({w0_gnt, w1_gnt} !== exp_g || {wr0, wr1} !== exp_g || address !== exp_addr) begin
        errors++;
        $display("FAIL alternate[%0d]: got gnt %b wr %b addr %h want gnt %b wr %b addr %h",
                 i, {w0_gnt, w1_gnt}, {wr0, wr1}, address, exp_g, exp_g, exp_addr);
      end
    end
  endtask

  task automatic test_starvation();
    logic [2:0] exp_v;
    apply_reset();
    rd_req = 1; rd_bank = 0; rd_addr = 12'h100;
    w1_req = 1; w1_bank = 0; w1_addr = 12'h200; w1_wdata = 12'h333;
    for (int i = 0; i < 7; i++) begin
      tick();
      exp_v = (i == int'(SM)) ? 3'b011 : 3'b100;
      checks++;
      if ({rd_gnt, w1_gnt, wr0} !== exp_v) begin
        errors++;
        $display("FAIL starvation[%0d]: got rd_gnt,w1_gnt,wr0 %b want %b",
                 i, {rd_gnt, w1_gnt, wr0}, exp_v);
      end
      if (i == int'(SM)) w1_req = 0;
    end
  endtask

  task automatic test_read_data();
    apply_reset();
    rd_req = 1; rd_bank = 0; rd_addr = 12'h020;
    tick();
    checks++;
    if ({rd_en, rd_gnt, rd_valid} !== 3'b110 || address !== 12'h020) begin
      errors++;
      $display("FAIL read_issue: got en,gnt,valid %b addr %h want 110 020",
               {rd_en, rd_gnt, rd_valid}, address);
    end
    rd_req = 0; b_rdata0 = 12'hABC; b_rdata1 = 12'h555;
    tick();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 12'hABC || rd_en !== 1'b0) begin
      errors++;
      $display("FAIL read_data_bank0: got valid %b data %h en %b want 1 abc 0",
               rd_valid, rd_data, rd_en);
    end
    b_rdata0 = 12'h123;
    rd_req = 1; rd_bank = 1; rd_addr = 12'h3FF;
    tick();
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 12'hABC) begin
      errors++;
      $display("FAIL read_data_hold: got valid %b data %h want 0 abc", rd_valid, rd_data);
    end
    rd_req = 0; b_rdata0 = 12'h777; b_rdata1 = 12'h9E1;
    tick();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 12'h9E1) begin
      errors++;
      $display("FAIL read_data_bank1: got valid %b data %h want 1 9e1", rd_valid, rd_data);
    end
  endtask

  task automatic test_reset_midop();
    apply_reset();
    rd_req = 1; rd_bank = 0; rd_addr = 12'h0AA;
    b_rdata0 = 12'hFFF;
    tick();
    checks++;
    if (rd_en !== 1'b1) begin
      errors++;
      $display("FAIL midop_precondition: got rd_en %b want 1", rd_en);
    end
    #2;
    reset = 1;
    rd_req = 0;
    #1;
    checks++;
    if ({rd_en, rd_gnt, wr0, wr1, rd_valid} !== 5'b0 || address !== '0) begin
      errors++;
      $display("FAIL midop_async_clear: got %b addr %h want 00000 000",
               {rd_en, rd_gnt, wr0, wr1, rd_valid}, address);
    end
    @(posedge clk);
    #3;
    reset = 0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({rd_en, wr0, wr1, rd_valid} !== 4'b0 || rd_data !== '0) begin
        errors++;
        $display("FAIL midop_after_release[%0d]: got en,wr0,wr1,valid %b data %h want 0000 000",
                 i, {rd_en, wr0, wr1, rd_valid}, rd_data);
      end
      tick();
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      b_rdata0 = DW'($urandom);
      b_rdata1 = DW'($urandom);
      model_edge();
      tick();
      checks++;
      if ({rd_en, rd_gnt, wr0, wr1, w0_gnt, w1_gnt, rd_valid} !==
          {m_rd_en, m_rd_en, m_wr0, m_wr1, m_w0g, m_w1g, m_valid}) begin
        errors++;
        $display("FAIL random_ctrl[%0d]: got %b want %b", c,
                 {rd_en, rd_gnt, wr0, wr1, w0_gnt, w1_gnt, rd_valid},
                 {m_rd_en, m_rd_en, m_wr0, m_wr1, m_w0g, m_w1g, m_valid});
      end
      checks++;
      if (address !== m_addr || wdata !== m_wdata || rd_data !== m_rdata) begin
        errors++;
        $display("FAIL random_data[%0d]: got %h/%h/%h want %h/%h/%h", c,
                 address, wdata, rd_data, m_addr, m_wdata, m_rdata);
      end
      checks++;
      if (32'(rd_en) + 32'(wr0) + 32'(wr1) > 1) begin
        errors++;
        $display("FAIL random_one_op[%0d]: got rd_en %b wr0 %b wr1 %b want at most one",
                 c, rd_en, wr0, wr1);
      end
      // Requesters hold until granted, then optionally issue a fresh request.
      if (m_rd_en || !rd_req) begin
        rd_req  = ($urandom_range(0, 3) != 0);
        rd_bank = 1'($urandom);
        rd_addr = AW'($urandom);
      end
      if (m_w0g || !w0_req) begin
        w0_req   = ($urandom_range(0, 1) != 0);
        w0_bank  = 1'($urandom);
        w0_addr  = AW'($urandom);
        w0_wdata = DW'($urandom);
      end
      if (m_w1g || !w1_req) begin
        w1_req   = ($urandom_range(0, 1) != 0);
        w1_bank  = 1'($urandom);
        w1_addr  = AW'($urandom);
        w1_wdata = DW'($urandom);
      end
    end
  endtask

  initial begin
    clear_inputs();
    model_reset();
    reset = 1;
    test_reset();
    test_single_write();
    test_alternate();
    test_starvation();
    test_read_data();
    test_reset_midop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
